// File: rtl/matrix_stream_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_pkg
//  Description : Shared definitions for the matrix transmit/transpose path:
//                default geometry, element indexing, complex conjugate helper
//                and the streamer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int MATRIX_SIZE       = 4;
    localparam int MATRIX_DATA_WIDTH = 32;
    localparam int MATRIX_COUNT      = MATRIX_SIZE * MATRIX_SIZE;
    localparam int MATRIX_AW         = $clog2(MATRIX_COUNT);
    localparam int MATRIX_HALF       = MATRIX_DATA_WIDTH / 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } tx_state_t;

    // Row-major element address.
    function automatic logic [MATRIX_AW-1:0] elem_index(input int unsigned row,
                                                         input int unsigned col);
        int unsigned idx;
        idx = row * MATRIX_SIZE + col;
        return idx[MATRIX_AW-1:0];
    endfunction

    // Complex conjugate {-(imag), real}; negation wraps, so the most negative
    // imaginary value maps to itself.
    function automatic logic [MATRIX_DATA_WIDTH-1:0] conj(input logic [MATRIX_DATA_WIDTH-1:0] elem);
        logic [MATRIX_HALF-1:0] imag_neg;
        imag_neg = ~elem[MATRIX_DATA_WIDTH-1:MATRIX_HALF] + {{(MATRIX_HALF-1){1'b0}}, 1'b1};
        return {imag_neg, elem[MATRIX_HALF-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_stream_tx_bank.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_bank
//  Description : One matrix buffer: simple dual-port synchronous RAM, one write
//                port and one read port with a single cycle of read latency.
//                The read output holds its value while i_rd_en is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_bank
    import matrix_pkg::*;
#(
    parameter int DEPTH      = MATRIX_COUNT,
    parameter int DATA_WIDTH = MATRIX_DATA_WIDTH,
    parameter int AW         = MATRIX_AW
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [AW-1:0]         i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Host write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read; holding the output lets the streamer stall without re-reading.
    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_stream_tx
//  Description : Double-buffered matrix source. The host fills one bank by
//                element address and commits it; the other bank streams
//                row-major as AXI-Stream with tlast on the final element.
//                Define MATRIX_TX_CONJ_EN to send the complex conjugate of
//                every element instead of the stored value.
//                Pipeline: issue (address) -> RAM read stage -> output register.
//                SIZE must be at least 2 so a bank is always fully drained
//                before the issue pointer can wrap back onto it.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_stream_tx
    import matrix_pkg::*;
#(
    parameter  int SIZE       = MATRIX_SIZE,
    parameter  int DATA_WIDTH = MATRIX_DATA_WIDTH,
    localparam int COUNT      = SIZE * SIZE,
    localparam int AW         = $clog2(COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_commit,
    output logic                  o_wr_bank_free,
    output logic [DATA_WIDTH-1:0] o_out_tdata,
    output logic                  o_out_tvalid,
    input  logic                  i_out_tready,
    output logic                  o_out_tlast,
    output logic                  o_busy
);

    localparam logic [AW-1:0] c_last_idx = AW'(COUNT - 1);

    logic [1:0]            r_full;
    logic                  r_wb;
    logic                  r_rb;
    logic                  r_ib;
    logic [AW-1:0]         r_cnt;
    tx_state_t             r_state;
    logic                  r_s1_valid;
    logic                  r_s1_last;
    logic                  r_s1_bank;

    logic                  w_wr_en;
    logic                  w_commit;
    logic                  w_hs_last;
    logic                  w_s2_load;
    logic                  w_s1_free;
    logic                  w_issue;
    logic                  w_issue_last;
    logic [DATA_WIDTH-1:0] w_rd_data [2];
    logic [DATA_WIDTH-1:0] w_s1_data;
    logic [DATA_WIDTH-1:0] w_out_elem;

    assign o_wr_bank_free = ~r_full[r_wb];
    assign o_busy         = r_full[0] | r_full[1] | o_out_tvalid;

    assign w_wr_en      = i_wr_en & o_wr_bank_free;
    assign w_commit     = i_wr_commit & o_wr_bank_free;
    assign w_hs_last    = o_out_tvalid & i_out_tready & o_out_tlast;
    assign w_s2_load    = r_s1_valid & (~o_out_tvalid | i_out_tready);
    assign w_s1_free    = ~r_s1_valid | w_s2_load;
    assign w_issue      = w_s1_free & ((r_state == ST_STREAM) | r_full[r_ib]);
    assign w_issue_last = w_issue & (r_cnt == c_last_idx);
    assign w_s1_data    = r_s1_bank ? w_rd_data[1] : w_rd_data[0];

`ifdef MATRIX_TX_CONJ_EN
    localparam int HALF = DATA_WIDTH / 2;
    logic [HALF-1:0] w_imag_neg;
    assign w_imag_neg = ~w_s1_data[DATA_WIDTH-1:HALF] + {{(HALF-1){1'b0}}, 1'b1};
    assign w_out_elem = {w_imag_neg, w_s1_data[HALF-1:0]};
`else
    assign w_out_elem = w_s1_data;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_bank
        matrix_bank #(
            .DEPTH      (COUNT),
            .DATA_WIDTH (DATA_WIDTH),
            .AW         (AW)
        ) u_bank (
            .clk       (clk),
            .i_wr_en   (w_wr_en & (r_wb == 1'(g))),
            .i_wr_addr (i_wr_addr),
            .i_wr_data (i_wr_data),
            .i_rd_en   (w_issue & (r_ib == 1'(g))),
            .i_rd_addr (r_cnt),
            .o_rd_data (w_rd_data[g])
        );
    end

    // Bank ownership: commit hands the write bank over, the tlast handshake
    // returns the read bank. They always address different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
            r_wb   <= 1'b0;
            r_rb   <= 1'b0;
        end else begin
            if (w_commit) begin
                r_full[r_wb] <= 1'b1;
                r_wb         <= ~r_wb;
            end
            if (w_hs_last) begin
                r_full[r_rb] <= 1'b0;
                r_rb         <= ~r_rb;
            end
        end
    end

    // Issue FSM: walks the address counter through a full bank, then moves
    // straight on to the other bank if it is already committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ib    <= 1'b0;
            r_cnt   <= '0;
        end else if (w_issue) begin
            if (w_issue_last) begin
                r_cnt   <= '0;
                r_ib    <= ~r_ib;
                r_state <= r_full[~r_ib] ? ST_STREAM : ST_IDLE;
            end else begin
                r_cnt   <= r_cnt + 1'b1;
                r_state <= ST_STREAM;
            end
        end
    end

    // RAM read stage bookkeeping: tracks which bank and beat the RAM output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_bank  <= 1'b0;
        end else if (w_issue) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= (r_cnt == c_last_idx);
            r_s1_bank  <= r_ib;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // AXI-Stream output register; only advances when empty or accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_out_tvalid <= 1'b0;
            o_out_tlast  <= 1'b0;
            o_out_tdata  <= '0;
        end else if (~o_out_tvalid | i_out_tready) begin
            o_out_tvalid <= r_s1_valid;
            o_out_tlast  <= r_s1_valid & r_s1_last;
            if (r_s1_valid) begin
                o_out_tdata <= w_out_elem;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_stream_tx
//  Description : Scoreboard testbench for matrix_stream_tx. Expected beats are
//                queued at commit time; a negedge monitor pops and compares
//                every accepted beat and checks stall stability.
//                Honours MATRIX_TX_CONJ_EN for expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_stream_tx;

    localparam int DW    = 32;
    localparam int COUNT = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_wr_en = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic          i_wr_commit = 1'b0;
    logic          o_wr_bank_free;
    logic [DW-1:0] o_out_tdata;
    logic          o_out_tvalid;
    logic          i_out_tready = 1'b0;
    logic          o_out_tlast;
    logic          o_busy;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            hs_count = 0;
    int            hs_cyc [$];
    exp_t          sb [$];
    exp_t          mon_e;
    logic [DW-1:0] mdl [2][COUNT];
    int            wb_m = 0;
    logic          rnd_mode = 1'b0;
    logic          tr_fixed = 1'b0;
    logic          have_prev = 1'b0;
    logic          in_frame = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_l = 1'b0;

    matrix_stream_tx u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_wr_en        (i_wr_en),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .i_wr_commit    (i_wr_commit),
        .o_wr_bank_free (o_wr_bank_free),
        .o_out_tdata    (o_out_tdata),
        .o_out_tvalid   (o_out_tvalid),
        .i_out_tready   (i_out_tready),
        .o_out_tlast    (o_out_tlast),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rnd_mode) i_out_tready = 1'($urandom_range(0, 1));
        else          i_out_tready = tr_fixed;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] exp_of(input logic [DW-1:0] v);
`ifdef MATRIX_TX_CONJ_EN
        logic [15:0] neg;
        neg = 16'h0000 - v[31:16];
        return {neg, v[15:0]};
`else
        return v;
`endif
    endfunction

    // Monitor: compares every accepted beat and checks stalled beats stay put.
    always @(negedge clk) begin
        if (rst) begin
            have_prev = 1'b0;
            in_frame  = 1'b0;
        end else begin
            if (have_prev) begin
                checks++;
                if (!o_out_tvalid || o_out_tdata !== prev_d || o_out_tlast !== prev_l) begin
                    errors++;
                    $display("FAIL stall_hold: tvalid=%0b tdata=0x%08h tlast=%0b, required 1/0x%08h/%0b",
                             o_out_tvalid, o_out_tdata, o_out_tlast, prev_d, prev_l);
                end
            end
            if (in_frame) begin
                checks++;
                if (!o_out_tvalid) begin
                    errors++;
                    $display("FAIL tvalid_gap: tvalid=0 mid-frame, required 1");
                end
            end
            have_prev = 1'b0;
            if (o_out_tvalid && !i_out_tready) begin
                have_prev = 1'b1;
                prev_d    = o_out_tdata;
                prev_l    = o_out_tlast;
            end
            if (o_out_tvalid && i_out_tready) begin
                hs_cyc.push_back(cyc);
                hs_count++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: tdata=0x%08h tlast=%0b, required no beat",
                             o_out_tdata, o_out_tlast);
                end else begin
                    mon_e = sb.pop_front();
                    if (o_out_tdata !== mon_e.d || o_out_tlast !== mon_e.l) begin
                        errors++;
                        $display("FAIL beat%0d: tdata=0x%08h tlast=%0b, required 0x%08h tlast=%0b",
                                 hs_count - 1, o_out_tdata, o_out_tlast, mon_e.d, mon_e.l);
                    end
                end
                in_frame = !o_out_tlast;
            end
        end
    end

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive_idle();
        i_wr_en     = 1'b0;
        i_wr_commit = 1'b0;
    endtask

    task automatic wait_free();
        int n = 0;
        while (!o_wr_bank_free && n < 4000) begin
            drive_idle();
            @(posedge clk); #1;
            n++;
        end
        if (!o_wr_bank_free) begin
            checks++;
            errors++;
            $display("FAIL wait_free: wr_bank_free=0, required 1 within bound");
        end
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [DW-1:0] e);
        @(posedge clk); #1;
        wait_free();
        i_wr_en     = 1'b1;
        i_wr_commit = 1'b0;
        i_wr_addr   = AW'(a);
        i_wr_data   = d;
        mdl[wb_m][a] = e;
    endtask

    task automatic commit();
        @(posedge clk); #1;
        wait_free();
        i_wr_en     = 1'b0;
        i_wr_commit = 1'b1;
        for (int i = 0; i < COUNT; i++) sb.push_back('{d: mdl[wb_m][i], l: (i == COUNT - 1)});
        wb_m ^= 1;
    endtask

    task automatic release_inputs();
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic load(input logic [DW-1:0] base);
        for (int i = 0; i < COUNT; i++) wr(i, base + DW'(i), exp_of(base + DW'(i)));
    endtask

    task automatic load_rand();
        logic [DW-1:0] d;
        for (int i = 0; i < COUNT; i++) begin
            d = $urandom;
            wr(i, d, exp_of(d));
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || o_out_tvalid) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0 || o_out_tvalid) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_count < target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int b;
        int n;
        logic [DW-1:0] e0;
        logic [DW-1:0] e3;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk1("rst_tvalid", o_out_tvalid, 1'b0);
        chk1("rst_tlast", o_out_tlast, 1'b0);
        chkd("rst_tdata", o_out_tdata, '0);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_free", o_wr_bank_free, 1'b1);

        // 1: single frame, latency and back-to-back beats
        tr_fixed = 1'b1;
        b = hs_count;
        load(0);
        commit();
        @(posedge clk); #1;
        drive_idle();
        chk1("t1_busy", o_busy, 1'b1);
        chk1("t1_tvalid_N", o_out_tvalid, 1'b0);
        @(posedge clk); #1;
        chk1("t1_tvalid_N1", o_out_tvalid, 1'b0);
        @(posedge clk); #1;
        chk1("t1_tvalid_N2", o_out_tvalid, 1'b1);
        drain("t1");
        @(posedge clk); #1;
        chk1("t1_busy_end", o_busy, 1'b0);
        chki("t1_beats", hs_count - b, 16);
        if (hs_count - b == 16) chki("t1_span", hs_cyc[b + 15] - hs_cyc[b], 15);

        // 2: second bank loaded and committed while first is pending
        tr_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b = hs_count;
        load(32'h0000_0100);
        commit();
        load(32'h0000_0200);
        commit();
        release_inputs();
        chk1("t2_free_both_full", o_wr_bank_free, 1'b0);
        tr_fixed = 1'b1;
        n = 0;
        while (hs_count < b + 16 && n < 200) begin
            if (hs_count == b + 15) chk1("t2_free_before_tlast", o_wr_bank_free, 1'b0);
            @(posedge clk); #1;
            n++;
        end
        chk1("t2_free_after_tlast", o_wr_bank_free, 1'b1);
        drain("t2");
        chki("t2_beats", hs_count - b, 32);
        if (hs_count - b == 32) begin
            checks++;
            if (hs_cyc[b + 16] - hs_cyc[b + 15] > 2) begin
                errors++;
                $display("FAIL t2_gap: %0d cycles between frames, required <= 2",
                         hs_cyc[b + 16] - hs_cyc[b + 15]);
            end
            chki("t2_span_b", hs_cyc[b + 31] - hs_cyc[b + 16], 15);
        end

        // 3: random backpressure across three frames
        rnd_mode = 1'b1;
        b = hs_count;
        load_rand();
        commit();
        load_rand();
        commit();
        load_rand();
        commit();
        release_inputs();
        drain("t3");
        chki("t3_beats", hs_count - b, 48);
        rnd_mode = 1'b0;

        // 4: writes and commit while both banks are full are dropped
        tr_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b = hs_count;
        load(32'h0000_0400);
        commit();
        load(32'h0000_0480);
        commit();
        release_inputs();
        chk1("t4_free_full", o_wr_bank_free, 1'b0);
        for (int i = 0; i < COUNT; i++) begin
            @(posedge clk); #1;
            i_wr_en   = 1'b1;
            i_wr_addr = AW'(i);
            i_wr_data = 32'hDEAD_0000 | DW'(i);
        end
        @(posedge clk); #1;
        i_wr_en     = 1'b0;
        i_wr_commit = 1'b1;
        release_inputs();
        chk1("t4_free_still_0", o_wr_bank_free, 1'b0);
        chk1("t4_busy", o_busy, 1'b1);
        tr_fixed = 1'b1;
        drain("t4");
        repeat (40) @(posedge clk);
        #1;
        chki("t4_beats", hs_count - b, 32);
        chk1("t4_idle_tvalid", o_out_tvalid, 1'b0);
        chk1("t4_idle_busy", o_busy, 1'b0);

        // 5: reset in the middle of a frame
        b = hs_count;
        load(32'h0000_0500);
        commit();
        release_inputs();
        wait_hs(b + 7);
        chki("t5_beats_pre_rst", hs_count - b, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk1("t5_tvalid", o_out_tvalid, 1'b0);
        chk1("t5_tlast", o_out_tlast, 1'b0);
        chkd("t5_tdata", o_out_tdata, '0);
        chk1("t5_free", o_wr_bank_free, 1'b1);
        chk1("t5_busy", o_busy, 1'b0);
        sb.delete();
        wb_m = 0;
        repeat (5) @(posedge clk);
        #1;
        b = hs_count;
        load(32'h0000_0600);
        commit();
        release_inputs();
        drain("t5");
        chki("t5_beats_fresh", hs_count - b, 16);

        // 6: conjugate boundary values (pass-through when the option is off)
`ifdef MATRIX_TX_CONJ_EN
        e0 = 32'hFFFD_0005;
        e3 = 32'h8001_1234;
`else
        e0 = 32'h0003_0005;
        e3 = 32'h7FFF_1234;
`endif
        b = hs_count;
        wr(0, 32'h0003_0005, e0);
        wr(1, 32'h8000_0001, 32'h8000_0001);
        wr(2, 32'h0000_0000, 32'h0000_0000);
        wr(3, 32'h7FFF_1234, e3);
        for (int i = 4; i < COUNT; i++) wr(i, 32'h0000_0700 + DW'(i), 32'h0000_0700 + DW'(i));
        commit();
        release_inputs();
        drain("t6");
        chki("t6_beats", hs_count - b, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
